man_dist_result_tx: RTL and testbench
=====================================

// Module: man_dist_result_tx
// PURPOSE
//  Downstream stage of the Manhattan-distance coprocessor. Captures the 3-byte result on the
//  rising edge of calc_ready and streams it, LSB byte first, into the UART transmitter over a
//  valid/ready byte handshake. Frees the calc block from any serial timing.
// PARAMETERS
//  BYTES_RESULT  3  number of result bytes per frame (19-bit result -> 3)
//  DATA_W        8  byte width on aux_result and tx_data
// PORTS
//  clk         in   1        system clock, all logic on posedge
//  reset       in   1        asynchronous, active-high reset
//  calc_ready  in   1        level from distance block, high while result valid
//  aux_result  in   8 x 3    result bytes, [0]=LSB
//  tx_ready    in   1        UART TX can accept a byte this cycle
//  tx_data     out  8        byte to transmit
//  tx_valid    out  1        tx_data valid; transfer when tx_valid & tx_ready
//  busy        out  1        frame in progress (state != IDLE)
//  done        out  1        one-cycle pulse after last byte accepted
//  overrun     out  1        sticky: trigger arrived while busy
// BEHAVIOUR
//  - Reset: state=IDLE, tx_data=0, tx_valid=0, busy=0, done=0, overrun=0, calc_ready_q=0.
//  - All outputs registered. trigger = calc_ready & ~calc_ready_q (rising edge only).
//  - States: IDLE, SEND, [CSUM], DONE.
//  - IDLE: on trigger, shadow <= aux_result, idx <= 0, state <= SEND; tx_valid high next cycle
//    (1-cycle latency trigger -> first byte presented); overrun cleared on accepted trigger.
//  - SEND: tx_valid=1, tx_data=shadow[idx]. tx_data/tx_valid held stable while !tx_ready.
//    On handshake: idx==BYTES_RESULT-1 -> DONE (or CSUM if enabled), else idx++ and next byte
//    presented next cycle (back-to-back bytes when tx_ready stays high).
//  - DONE: tx_valid=0, done=1 for exactly one cycle, -> IDLE. trigger in DONE counts as busy.
//  - calc_ready held high any length -> exactly one frame. Falls and re-rises -> new frame.
//  - trigger while busy: ignored, frame content unchanged (shadow not reloaded), overrun<=1.
//  - aux_result changes mid-frame: no effect (shadow captured at trigger).
//  - reset mid-frame: immediate return to reset values; partial frame abandoned.
//  - idx width $clog2(BYTES_RESULT+1); no wrap past BYTES_RESULT-1.
// CONFIGURATION
//  MAN_DIST_TX_CHECKSUM_EN defined: after last result byte, state CSUM presents
//    tx_data = XOR of all shadow bytes with same handshake rules, then DONE.
//    Frame = BYTES_RESULT+1 bytes.
//  Undefined: no CSUM state, frame = BYTES_RESULT bytes, SEND -> DONE directly.
// STRUCTURE
//  - Package man_dist_pkg: typedef enum logic [1:0] {IDLE,SEND,CSUM,DONE} tx_state_t;
//    localparam BYTES_RESULT=3; byte_t = logic [7:0]; MAN_DIST_OP=8'd103.
//  - Sub-module rise_edge_det (clk, reset, d -> pulse): registered edge detector,
//    reusable by other op blocks.
//  - Single FSM always_ff with async reset; no other sub-modules.
// TESTING
//  1. aux_result={8'h01,8'h23,8'h45}, tx_ready=1, calc_ready 0->1 -> tx_data 8'h45,8'h23,8'h01
//     on 3 consecutive cycles starting 1 cycle after edge; done pulses 1 cycle after 8'h01.
//  2. Same, tx_ready low 5 cycles while 8'h45 offered -> tx_data=8'h45, tx_valid=1 held all 5
//     cycles; sequence resumes on tx_ready=1, no byte lost or duplicated.
//  3. calc_ready held high 100 cycles -> exactly 3 handshakes, one done pulse, overrun=0.
//  4. Second calc_ready edge during byte 2, aux_result changed to 8'hFF -> frame still
//     45/23/01, overrun=1 after frame; next accepted trigger clears overrun.
//  5. reset asserted while idx=1 -> same cycle tx_valid=0, busy=0; new trigger after release
//     restarts from 8'h45.
//  6. MAN_DIST_TX_CHECKSUM_EN defined, stimulus of (1) -> 4 bytes 8'h45,8'h23,8'h01,8'h67;
//     done after 8'h67.

Source files
------------

// File: rtl/man_dist_pkg.sv
// Shared types and constants for the Manhattan-distance coprocessor blocks.
package man_dist_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      CSUM = 2'd2,
      DONE = 2'd3
   } tx_state_t;

   localparam int BYTES_RESULT = 3;

   typedef logic [7:0] byte_t;

   localparam byte_t MAN_DIST_OP = 8'd103;

endpackage

// File: rtl/rise_edge_det.sv
// Registered rising-edge detector: pulse is high while d is high and was low last cycle.
module rise_edge_det (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic pulse
);

   logic r_d_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_d_q <= 1'b0;
      else       r_d_q <= d;
   end

   assign pulse = d & ~r_d_q;

endmodule

// File: rtl/man_dist_result_tx.sv
// Streams the captured distance result, LSB byte first, into the UART TX byte handshake.
// Optional feature: define MAN_DIST_TX_CHECKSUM_EN to append an XOR checksum byte.
module man_dist_result_tx
   import man_dist_pkg::*;
#(
   parameter int BYTES_RESULT = man_dist_pkg::BYTES_RESULT,
   parameter int DATA_W       = 8
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 calc_ready,
   input  logic [BYTES_RESULT-1:0][DATA_W-1:0]  aux_result,
   input  logic                                 tx_ready,
   output logic [DATA_W-1:0]                    tx_data,
   output logic                                 tx_valid,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 overrun
);

   localparam int                IDX_W    = $clog2(BYTES_RESULT + 1);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BYTES_RESULT - 1);

   tx_state_t                              r_state, w_state_nxt;
   logic [BYTES_RESULT-1:0][DATA_W-1:0]    r_shadow, w_shadow_nxt;
   logic [IDX_W-1:0]                       r_idx, w_idx_nxt, w_idx_inc;
   logic [DATA_W-1:0]                      r_tx_data, w_tx_data_nxt;
   logic                                   r_tx_valid, w_tx_valid_nxt;
   logic                                   r_busy, r_done, w_done_nxt;
   logic                                   r_overrun, w_overrun_nxt;
   logic                                   w_trigger, w_hs;

   rise_edge_det u_rise_edge_det (
      .clk   (clk),
      .reset (reset),
      .d     (calc_ready),
      .pulse (w_trigger)
   );

`ifdef MAN_DIST_TX_CHECKSUM_EN
   logic [DATA_W-1:0] w_csum;

   always_comb begin
      w_csum = '0;
      for (int i = 0; i < BYTES_RESULT; i++) w_csum = w_csum ^ r_shadow[i];
   end
`endif

   assign w_hs      = r_tx_valid & tx_ready;
   assign w_idx_inc = r_idx + 1'b1;

   // NOTE: every variable gets a hold/default value first, so no path can infer a latch.
   always_comb begin
      w_state_nxt    = r_state;
      w_shadow_nxt   = r_shadow;
      w_idx_nxt      = r_idx;
      w_tx_data_nxt  = r_tx_data;
      w_tx_valid_nxt = r_tx_valid;
      w_done_nxt     = 1'b0;
      w_overrun_nxt  = r_overrun;

      // A trigger in any state but IDLE (DONE included) is dropped and flagged.
      if (w_trigger && r_state != IDLE) w_overrun_nxt = 1'b1;

      case (r_state)
         IDLE: begin
            if (w_trigger) begin
               w_shadow_nxt   = aux_result;
               w_idx_nxt      = '0;
               w_tx_data_nxt  = aux_result[0];
               w_tx_valid_nxt = 1'b1;
               w_overrun_nxt  = 1'b0;
               w_state_nxt    = SEND;
            end
         end
         SEND: begin
            if (w_hs) begin
               if (r_idx == LAST_IDX) begin
`ifdef MAN_DIST_TX_CHECKSUM_EN
                  w_tx_data_nxt  = w_csum;
                  w_state_nxt    = CSUM;
`else
                  w_tx_valid_nxt = 1'b0;
                  w_done_nxt     = 1'b1;
                  w_state_nxt    = DONE;
`endif
               end else begin
                  w_idx_nxt     = w_idx_inc;
                  w_tx_data_nxt = r_shadow[w_idx_inc];
               end
            end
         end
         CSUM: begin
            if (w_hs) begin
               w_tx_valid_nxt = 1'b0;
               w_done_nxt     = 1'b1;
               w_state_nxt    = DONE;
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_tx_valid_nxt = 1'b0;
            w_state_nxt    = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_shadow   <= '0;
         r_idx      <= '0;
         r_tx_data  <= '0;
         r_tx_valid <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_shadow   <= w_shadow_nxt;
         r_idx      <= w_idx_nxt;
         r_tx_data  <= w_tx_data_nxt;
         r_tx_valid <= w_tx_valid_nxt;
         r_busy     <= (w_state_nxt != IDLE);
         r_done     <= w_done_nxt;
         r_overrun  <= w_overrun_nxt;
      end
   end

   assign tx_data  = r_tx_data;
   assign tx_valid = r_tx_valid;
   assign busy     = r_busy;
   assign done     = r_done;
   assign overrun  = r_overrun;

endmodule

// File: tb/tb_man_dist_result_tx.sv
// Directed scoreboard bench for man_dist_result_tx (honours MAN_DIST_TX_CHECKSUM_EN).
module tb_man_dist_result_tx;

   logic             clk = 1'b0;
   logic             reset;
   logic             calc_ready;
   logic [2:0][7:0]  aux_result;
   logic             tx_ready;
   logic [7:0]       tx_data;
   logic             tx_valid;
   logic             busy;
   logic             done;
   logic             overrun;

   int               n_checks = 0;
   int               n_errors = 0;
   int               hs_cnt   = 0;
   int               done_cnt = 0;
   logic [7:0]       sb[$];

   man_dist_result_tx dut (
      .clk        (clk),
      .reset      (reset),
      .calc_ready (calc_ready),
      .aux_result (aux_result),
      .tx_ready   (tx_ready),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .busy       (busy),
      .done       (done),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected frame for the current aux_result, pushed when the trigger is driven.
   task automatic push_frame();
      logic [7:0] x;
      x = 8'h00;
      for (int i = 0; i < 3; i++) begin
         sb.push_back(aux_result[i]);
         x = x ^ aux_result[i];
      end
`ifdef MAN_DIST_TX_CHECKSUM_EN
      sb.push_back(x);
`endif
   endtask

   // Observe at negedge (handshake about to complete), then advance past the next posedge.
   task automatic tick();
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
         hs_cnt++;
         if (sb.size() == 0) chk("sb_underflow", 32'(sb.size()), 32'd1);
         else                chk("byte", 32'(tx_data), 32'(sb.pop_front()));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_until_done(input string tag, input int max_cycles);
      int start;
      start = done_cnt;
      for (int i = 0; i < max_cycles; i++) begin
         tick();
         if (done_cnt > start) break;
      end
      chk(tag, 32'(done_cnt > start), 32'd1);
   endtask

   initial begin
      int hs0, dn0;
      reset      = 1'b1;
      calc_ready = 1'b0;
      tx_ready   = 1'b1;
      aux_result = {8'h01, 8'h23, 8'h45};
      repeat (2) @(posedge clk);
      #1;
      chk("rst_tx_valid", 32'(tx_valid), 32'd0);
      chk("rst_tx_data",  32'(tx_data),  32'd0);
      chk("rst_busy",     32'(busy),     32'd0);
      chk("rst_done",     32'(done),     32'd0);
      chk("rst_overrun",  32'(overrun),  32'd0);
      reset = 1'b0;
      tick();

      // 1: back-to-back frame, one cycle latency from the rising edge
      calc_ready = 1'b1;
      push_frame();
      tick();
      chk("t1_first_valid", 32'(tx_valid), 32'd1);
      chk("t1_first_data",  32'(tx_data),  32'h45);
      chk("t1_busy",        32'(busy),     32'd1);
`ifdef MAN_DIST_TX_CHECKSUM_EN
      repeat (4) tick();
`else
      repeat (3) tick();
`endif
      chk("t1_done_pulse", 32'(done),     32'd1);
      chk("t1_valid_off",  32'(tx_valid), 32'd0);
      chk("t1_sb_empty",   32'(sb.size()), 32'd0);
      tick();
      chk("t1_done_1cyc",  32'(done), 32'd0);
      chk("t1_idle",       32'(busy), 32'd0);
      calc_ready = 1'b0;
      tick();

      // 2: stall on the first byte for five cycles
      tx_ready   = 1'b0;
      calc_ready = 1'b1;
      push_frame();
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("t2_hold_valid", 32'(tx_valid), 32'd1);
         chk("t2_hold_data",  32'(tx_data),  32'h45);
         tick();
      end
      tx_ready = 1'b1;
      run_until_done("t2_done_timeout", 20);
      chk("t2_sb_empty", 32'(sb.size()), 32'd0);
      calc_ready = 1'b0;
      repeat (2) tick();

      // 3: calc_ready held high for 100 cycles gives exactly one frame
      hs0 = hs_cnt;
      dn0 = done_cnt;
      calc_ready = 1'b1;
      push_frame();
      repeat (100) tick();
`ifdef MAN_DIST_TX_CHECKSUM_EN
      chk("t3_handshakes", 32'(hs_cnt - hs0), 32'd4);
`else
      chk("t3_handshakes", 32'(hs_cnt - hs0), 32'd3);
`endif
      chk("t3_done_count", 32'(done_cnt - dn0), 32'd1);
      chk("t3_overrun",    32'(overrun), 32'd0);
      chk("t3_sb_empty",   32'(sb.size()), 32'd0);
      calc_ready = 1'b0;
      tick();

      // 4: retrigger with new data while byte 2 is offered
      push_frame();
      calc_ready = 1'b1;
      tick();
      tick();
      chk("t4_byte2_offered", 32'(tx_data), 32'h23);
      tx_ready   = 1'b0;
      calc_ready = 1'b0;
      tick();
      calc_ready = 1'b1;
      aux_result = {8'hFF, 8'hFF, 8'hFF};
      tick();
      chk("t4_overrun_set", 32'(overrun), 32'd1);
      tx_ready = 1'b1;
      run_until_done("t4_done_timeout", 20);
      tick();
      chk("t4_overrun_sticky", 32'(overrun), 32'd1);
      chk("t4_sb_empty",       32'(sb.size()), 32'd0);
      calc_ready = 1'b0;
      aux_result = {8'h01, 8'h23, 8'h45};
      tick();
      calc_ready = 1'b1;
      push_frame();
      tick();
      chk("t4_overrun_clear", 32'(overrun), 32'd0);
      run_until_done("t4b_done_timeout", 20);
      chk("t4b_sb_empty", 32'(sb.size()), 32'd0);
      calc_ready = 1'b0;
      repeat (2) tick();

      // 5: reset while idx=1 abandons the frame immediately
      calc_ready = 1'b1;
      push_frame();
      tick();
      tick();
      chk("t5_idx1_data", 32'(tx_data), 32'h23);
      reset = 1'b1;
      #1;
      chk("t5_rst_valid", 32'(tx_valid), 32'd0);
      chk("t5_rst_busy",  32'(busy),     32'd0);
      sb.delete();
      calc_ready = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      calc_ready = 1'b1;
      push_frame();
      tick();
      chk("t5_restart_data", 32'(tx_data), 32'h45);
      run_until_done("t5_done_timeout", 20);
      chk("t5_sb_empty", 32'(sb.size()), 32'd0);
      calc_ready = 1'b0;
      repeat (2) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
